// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/interrupt controller:
// FSM encoding, register-id and counter widths, INIT duration.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ID_W    = 5;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned INIT_CYCLES = 2;

  localparam logic [REG_ID_W-1:0] REG_NONE = '0;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    INT_WAIT = 2'd2,
    INT_ACK  = 2'd3
  } state_t;

  // Per-latch control bundle produced by the output decode
  typedef struct packed {
    logic pc_stall;
    logic if_stall;
    logic if_flush;
    logic id_stall;
    logic id_flush;
    logic exe_stall;
    logic exe_flush;
    logic mem_stall;
  } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signal bundle: hazard sources in, per-stage stall/flush out.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_ID_W-1:0] ID_src1_id;
  logic [REG_ID_W-1:0] ID_src2_id;
  logic [REG_ID_W-1:0] EXE_wr_id;
  logic                EXE_is_load;
  logic                EXE_EOI;
  logic                branch_taken;
  logic                mem_busy;

  logic PC_stall;
  logic IF_stall;
  logic IF_flush;
  logic ID_stall;
  logic ID_flush;
  logic EXE_stall;
  logic EXE_flush;
  logic MEM_stall;

  // master: the controller; slave: the pipeline datapath
  modport master (
    input  ID_src1_id, ID_src2_id, EXE_wr_id, EXE_is_load, EXE_EOI,
           branch_taken, mem_busy,
    output PC_stall, IF_stall, IF_flush, ID_stall, ID_flush,
           EXE_stall, EXE_flush, MEM_stall
  );

  modport slave (
    output ID_src1_id, ID_src2_id, EXE_wr_id, EXE_is_load, EXE_EOI,
           branch_taken, mem_busy,
    input  PC_stall, IF_stall, IF_flush, ID_stall, ID_flush,
           EXE_stall, EXE_flush, MEM_stall
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection between the EXE destination and the ID sources.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ID_W-1:0] src1_id,
  input  logic [REG_ID_W-1:0] src2_id,
  input  logic [REG_ID_W-1:0] wr_id,
  input  logic                is_load,
  output logic                load_use
);

  assign load_use = is_load && (wr_id != REG_NONE) &&
                    ((wr_id == src1_id) || (wr_id == src2_id));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: INIT/RUN/interrupt FSM, stall/flush decode with
// mem_busy > branch > load-use priority, and a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_ctrl_if.master      pif,
  input  logic                 int_req,
  input  logic                 cnt_clr,
  output logic                 int_ack,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned INIT_CNT_W = $clog2(INIT_CYCLES + 1);

  state_t                state_q, state_nx;
  logic [INIT_CNT_W-1:0] init_cnt;
  logic                  load_use;
  ctrl_t                 ctrl;

  hazard_detect u_hazard_detect (
    .src1_id  (pif.ID_src1_id),
    .src2_id  (pif.ID_src2_id),
    .wr_id    (pif.EXE_wr_id),
    .is_load  (pif.EXE_is_load),
    .load_use (load_use)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q  <= state_nx;
      init_cnt <= (state_q == INIT) ? init_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state_q;
    ctrl     = '0;
    int_ack  = 1'b0;
    unique case (state_q)
      INIT: begin
        ctrl.pc_stall  = 1'b1;
        ctrl.if_flush  = 1'b1;
        ctrl.id_flush  = 1'b1;
        ctrl.exe_flush = 1'b1;
        if (init_cnt == INIT_CNT_W'(INIT_CYCLES - 1)) state_nx = RUN;
      end
      RUN, INT_WAIT: begin
        if (pif.mem_busy) begin
          // full freeze: no transition, no flush
          ctrl.pc_stall  = 1'b1;
          ctrl.if_stall  = 1'b1;
          ctrl.id_stall  = 1'b1;
          ctrl.exe_stall = 1'b1;
          ctrl.mem_stall = 1'b1;
        end else begin
          if (pif.branch_taken) begin
            ctrl.if_flush = 1'b1;
            ctrl.id_flush = 1'b1;
          end else if (load_use) begin
            ctrl.pc_stall = 1'b1;
            ctrl.if_stall = 1'b1;
            ctrl.id_flush = 1'b1;
          end
          if (state_q == RUN && int_req)
            state_nx = INT_WAIT;
          else if (state_q == INT_WAIT && pif.EXE_EOI && !pif.branch_taken)
            state_nx = INT_ACK;
        end
      end
      INT_ACK: begin
        int_ack        = 1'b1;
        ctrl.if_flush  = 1'b1;
        ctrl.id_flush  = 1'b1;
        ctrl.exe_flush = 1'b1;
        state_nx       = RUN;
      end
      default: state_nx = INIT;
    endcase
  end

  assign pif.PC_stall  = ctrl.pc_stall;
  assign pif.IF_stall  = ctrl.if_stall;
  assign pif.IF_flush  = ctrl.if_flush;
  assign pif.ID_stall  = ctrl.id_stall;
  assign pif.ID_flush  = ctrl.id_flush;
  assign pif.EXE_stall = ctrl.exe_stall;
  assign pif.EXE_flush = ctrl.exe_flush;
  assign pif.MEM_stall = ctrl.mem_stall;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (state_q != INIT && ctrl.pc_stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the control rules.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        int_req = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        int_ack;
  logic [15:0] stall_cnt;

  pipeline_ctrl_if pif ();

  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .pif       (pif),
    .int_req   (int_req),
    .cnt_clr   (cnt_clr),
    .int_ack   (int_ack),
    .stall_cnt (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: cycles of INIT left, interrupt pending EOI, ack this cycle, counter
  int          init_left;
  bit          waiting;
  bit          ack_now;
  int unsigned m_cnt;

  // Vector order: {PC_stall, IF_stall, IF_flush, ID_stall, ID_flush, EXE_stall, EXE_flush, MEM_stall}
  function automatic logic [7:0] model_ctrl();
    logic lu;
    lu = pif.EXE_is_load && (pif.EXE_wr_id != 5'd0) &&
         ((pif.EXE_wr_id == pif.ID_src1_id) || (pif.EXE_wr_id == pif.ID_src2_id));
    if (init_left > 0)         return 8'b1010_1010;
    else if (ack_now)          return 8'b0010_1010;
    else if (pif.mem_busy)     return 8'b1101_0101;
    else if (pif.branch_taken) return 8'b0010_1000;
    else if (lu)               return 8'b1100_1000;
    else                       return 8'b0000_0000;
  endfunction

  function automatic logic [7:0] obs_ctrl();
    return {pif.PC_stall, pif.IF_stall, pif.IF_flush, pif.ID_stall,
            pif.ID_flush, pif.EXE_stall, pif.EXE_flush, pif.MEM_stall};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1: drive, check at negedge, advance model at posedge.
  task automatic cycle(input logic mb, br, lo, eoi, ir, clr,
                       input logic [4:0] wr, s1, s2);
    logic [7:0] exp;
    pif.mem_busy     = mb;
    pif.branch_taken = br;
    pif.EXE_is_load  = lo;
    pif.EXE_EOI      = eoi;
    pif.EXE_wr_id    = wr;
    pif.ID_src1_id   = s1;
    pif.ID_src2_id   = s2;
    int_req          = ir;
    cnt_clr          = clr;
    @(negedge CLK);
    exp = model_ctrl();
    chk("ctrl", 32'(obs_ctrl()), 32'(exp));
    chk("int_ack", 32'(int_ack), 32'(ack_now && init_left == 0));
    chk("stall_cnt", 32'(stall_cnt), m_cnt);
    @(posedge CLK);
    if (clr) m_cnt = 0;
    else if (init_left == 0 && exp[7] && m_cnt < 32'hFFFF) m_cnt++;
    if (init_left > 0) init_left--;
    else if (ack_now) ack_now = 1'b0;
    else if (!mb) begin
      if (waiting) begin
        if (eoi && !br) begin
          waiting = 1'b0;
          ack_now = 1'b1;
        end
      end else if (ir) begin
        waiting = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Asserts reset mid-cycle, checks the reset-held outputs, releases at posedge+1.
  task automatic do_reset();
    #1;
    RST = 1'b0;
    #1;
    chk("rst_ctrl", 32'(obs_ctrl()), 32'h0000_00AA);
    chk("rst_int_ack", 32'(int_ack), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_hold_ctrl", 32'(obs_ctrl()), 32'h0000_00AA);
    init_left = INIT_CYCLES;
    waiting   = 1'b0;
    ack_now   = 1'b0;
    m_cnt     = 0;
    RST = 1'b1;
  endtask

  initial begin
    logic        mb, br, lo, eoi, ir, clr;
    logic [4:0]  wr, s1, s2;
    logic [15:0] c0;

    pif.mem_busy = 0; pif.branch_taken = 0; pif.EXE_is_load = 0; pif.EXE_EOI = 0;
    pif.EXE_wr_id = 0; pif.ID_src1_id = 0; pif.ID_src2_id = 0;
    @(posedge CLK);
    do_reset();

    // INIT for two cycles, then quiet RUN
    idle(); idle(); idle(); idle();

    // Load-use on src2, then the same with destination r0
    c0 = stall_cnt;
    cycle(0, 0, 1, 0, 0, 0, 5'd3, 5'd0, 5'd3);
    chk("lu_cnt_inc", 32'(stall_cnt), 32'(c0) + 1);
    c0 = stall_cnt;
    cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("lu_r0_no_inc", 32'(stall_cnt), 32'(c0));

    // mem_busy dominates branch and load-use for 4 cycles, then branch flush
    c0 = stall_cnt;
    repeat (4) cycle(1, 1, 1, 0, 0, 0, 5'd3, 5'd3, 5'd1);
    chk("busy_cnt_plus4", 32'(stall_cnt), 32'(c0) + 4);
    cycle(0, 1, 1, 0, 0, 0, 5'd3, 5'd3, 5'd1);
    idle();

    // One-cycle interrupt request, EOI three cycles later
    cycle(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(); idle();
    cycle(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("int_ack_pulse", 32'(int_ack), 32'd1);
    idle();
    chk("int_ack_one_cycle", 32'(int_ack), 32'd0);
    idle();

    // Random traffic with a small register-id range to provoke hazards
    repeat (3000) begin
      mb  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 7) == 0);
      lo  = 1'($urandom_range(0, 1));
      eoi = ($urandom_range(0, 3) == 0);
      ir  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 63) == 0);
      wr  = 5'($urandom_range(0, 3));
      s1  = 5'($urandom_range(0, 3));
      s2  = 5'($urandom_range(0, 3));
      cycle(mb, br, lo, eoi, ir, clr, wr, s1, s2);
    end
    idle(); idle();

    // Reset while an interrupt is pending; no ack may follow
    cycle(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    do_reset();
    repeat (6) cycle(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);

    // Counter saturation and clear-over-increment
    cycle(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    repeat (65534) cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("cnt_preset_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    repeat (3) cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("cnt_saturated", 32'(stall_cnt), 32'h0000_FFFF);
    cycle(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    chk("cnt_clr_priority", 32'(stall_cnt), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
